alu_exec_engine: RTL and testbench
==================================

Name: alu_exec_engine

Overview:
- Sits between FIFO_IN and FIFO_OUT of the APB-controlled ALU.
- Pops one operation word, {op, data1, data0}, from FIFO_IN whenever FIFO_IN is not empty.
- Executes ADD in one cycle, or MUL as a multi-cycle shift-add.
- Pushes one 25-bit result word, {err, result}, into FIFO_OUT. The CSR control block later reads that word back over APB.

Parameters:
- DATA_WIDTH, 12, width of each operand.
- OPERATION_SIZE, 2, width of the op code.
- FIFO_IN_WIDTH, 26, equals OPERATION_SIZE + 2*DATA_WIDTH.
- FIFO_OUT_WIDTH, 25, equals 1 + 2*DATA_WIDTH.
- CNT_WIDTH, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- empty_in  in  1  FIFO_IN empty flag.
- rdata_in  in  FIFO_IN_WIDTH  FIFO_IN read data, valid one cycle after r_en_in. Packing: {op[25:24], data1[23:12], data0[11:0]}.
- r_en_in  out  1  FIFO_IN pop strobe, one cycle wide.
- full_out  in  1  FIFO_OUT full flag.
- w_en_out  out  1  FIFO_OUT push strobe, one cycle wide.
- wdata_out  out  FIFO_OUT_WIDTH  result word {err, result[23:0]}, valid while w_en_out=1.
- busy  out  1  high in every state except IDLE.
- ops_done  out  CNT_WIDTH  count of pushed results, wraps around.

Behaviour:
- Reset: asynchronous on rst_n=0.
  - State goes to IDLE.
  - r_en_in=0, w_en_out=0, wdata_out=0, busy=0, ops_done=0.
  - Operand, accumulator and step-counter registers are all cleared.
- All outputs are registered or decoded from state (Moore). There are no combinational paths from inputs to outputs.
- FSM states and transitions:
  - IDLE: if empty_in=0, go to FETCH; otherwise stay.
  - FETCH: r_en_in=1 for exactly this cycle; go to LOAD.
  - LOAD: capture op, data0, data1 from rdata_in (FIFO read latency is one cycle); go to EXEC.
  - EXEC, op=2'b01 (ADD): result = zero-extended data0 + data1, 13 significant bits; go to PUSH after 1 cycle.
  - EXEC, op=2'b10 (MUL): one shift-add step per cycle, DATA_WIDTH cycles in total. The step counter counts 0..DATA_WIDTH-1; at the last step go to PUSH. result is 24-bit unsigned.
  - EXEC, op=2'b00 or 2'b11 (invalid): result=0, err=1; go to PUSH after 1 cycle. CSR already filters invalid ops; this path is defensive.
  - PUSH: if full_out=0, assert w_en_out=1 for one cycle, drive wdata_out, increment ops_done, and return to IDLE. If full_out=1, hold in PUSH with w_en_out=0 and keep the result stable.
- Latency, counted in edges from the first IDLE cycle with empty_in=0 to the w_en_out cycle, with FIFO_OUT not full:
  - ADD and invalid: 4.
  - MUL: 3 + DATA_WIDTH, i.e. 15.
- One operation is in flight at a time. There is no pop while busy, and there is no pipelining.
- Boundary conditions:
  - empty_in is only sampled in IDLE. A rise of empty_in during FETCH is an upstream protocol error and is not checked.
  - Back-to-back operations: after PUSH, the machine returns to IDLE for one cycle before the next FETCH, so pushes are spaced at least 5 cycles apart.
  - ops_done wraps from 2^CNT_WIDTH-1 to 0.
  - Reset mid-EXEC or mid-PUSH: the in-flight operation is dropped, no push occurs, and all outputs go to their reset values immediately.

Decomposition:
- Shared package alu_pkg holds:
  - OP_ADD=2'b01, OP_MUL=2'b10.
  - State encoding for IDLE, FETCH, LOAD, EXEC, PUSH.
  - FIFO_IN field offsets.
  - FIFO_OUT err bit index (24).
- Sub-module shift_add_multiplier holds the multiplier datapath.
  - Inputs: start, a, b. Outputs: product, done.
  - Runs DATA_WIDTH cycles and pulses done on the last step.
  - The FSM, counter and FIFO handshakes stay in the top module.

Test Plan:
- ADD: FIFO_IN word {01, 12'h001, 12'hFFF}, FIFO_OUT not full -> single r_en_in pulse; w_en_out 4 cycles later with wdata_out=25'h0001000; ops_done=1.
- MUL: {10, 12'hFFF, 12'hFFF} -> w_en_out exactly 15 cycles later with wdata_out=25'h0FFE001; busy high throughout.
- Invalid op: {00, 12'h005, 12'h003} -> wdata_out=25'h1000000 (err=1, result=0); ops_done increments.
- Backpressure: full_out=1 from PUSH entry for 5 cycles -> w_en_out=0 and wdata_out stable; w_en_out pulses on the first cycle with full_out=0; exactly one push.
- Reset mid-MUL: rst_n low at EXEC step 6 -> busy=0, r_en_in=0, w_en_out=0, ops_done=0 immediately; no push after release with empty_in=1.
- Back-to-back: three ADD words queued -> three single-cycle r_en_in and w_en_out pulses, results in order, pushes 5 cycles apart; ops_done=3.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, op codes, FIFO word layout and FSM states for the ALU exec engine
package alu_pkg;

  localparam int ALU_DATA_WIDTH      = 12;
  localparam int ALU_OPERATION_SIZE  = 2;
  localparam int ALU_FIFO_IN_WIDTH   = ALU_OPERATION_SIZE + 2 * ALU_DATA_WIDTH;
  localparam int ALU_FIFO_OUT_WIDTH  = 1 + 2 * ALU_DATA_WIDTH;
  localparam int ALU_CNT_WIDTH       = 8;

  localparam logic [ALU_OPERATION_SIZE-1:0] OP_ADD = 2'b01;
  localparam logic [ALU_OPERATION_SIZE-1:0] OP_MUL = 2'b10;

  // FIFO_IN word is {op, data1, data0}; FIFO_OUT word is {err, result}
  localparam int IN_D0_LSB   = 0;
  localparam int IN_D1_LSB   = ALU_DATA_WIDTH;
  localparam int IN_OP_LSB   = 2 * ALU_DATA_WIDTH;
  localparam int OUT_ERR_BIT = 2 * ALU_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_PUSH  = 3'd4
  } state_e;

endpackage

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - unsigned shift-add multiplier, one partial product per cycle over WIDTH cycles
module shift_add_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, acc_q, cur_mcand, cur_acc, acc_d;
  logic [WIDTH-1:0]   mplier_q, cur_mplier;
  logic [CW-1:0]      cnt_q, cur_cnt;
  logic               running_q, active;

  // start folds step 0 into the same cycle, so the last step lands WIDTH-1 cycles later
  always_comb begin
    active     = start | running_q;
    cur_mcand  = start ? {{WIDTH{1'b0}}, a} : mcand_q;
    cur_mplier = start ? b : mplier_q;
    cur_acc    = start ? '0 : acc_q;
    cur_cnt    = start ? '0 : cnt_q;
    acc_d      = cur_acc + (cur_mplier[0] ? cur_mcand : '0);
    done       = active && (cur_cnt == CW'(WIDTH - 1));
    product    = acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else if (active) begin
      acc_q     <= acc_d;
      mcand_q   <= cur_mcand << 1;
      mplier_q  <= cur_mplier >> 1;
      cnt_q     <= cur_cnt + CW'(1);
      running_q <= !done;
    end
  end

endmodule

// File: rtl/alu_exec_engine.sv
// rtl/alu_exec_engine.sv - pops an op word from FIFO_IN, runs ADD or MUL, pushes {err, result} to FIFO_OUT
module alu_exec_engine
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = ALU_DATA_WIDTH,
  parameter int OPERATION_SIZE = ALU_OPERATION_SIZE,
  parameter int FIFO_IN_WIDTH  = ALU_FIFO_IN_WIDTH,
  parameter int FIFO_OUT_WIDTH = ALU_FIFO_OUT_WIDTH,
  parameter int CNT_WIDTH      = ALU_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      empty_in,
  input  logic [FIFO_IN_WIDTH-1:0]  rdata_in,
  output logic                      r_en_in,
  input  logic                      full_out,
  output logic                      w_en_out,
  output logic [FIFO_OUT_WIDTH-1:0] wdata_out,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      ops_done
);

  state_e                      state_q;
  logic                        r_en_q, w_en_q, first_q;
  logic [FIFO_OUT_WIDTH-1:0]   wdata_q;
  logic [CNT_WIDTH-1:0]        ops_q;
  logic [OPERATION_SIZE-1:0]   op_q;
  logic [DATA_WIDTH-1:0]       d0_q, d1_q;

  logic                        mul_start, mul_done;
  logic [2*DATA_WIDTH-1:0]     mul_product;
  logic [DATA_WIDTH:0]         sum_d;
  logic [2*DATA_WIDTH-1:0]     result_d;
  logic                        err_d, exec_done_d;

  assign mul_start = (state_q == S_EXEC) && first_q && (op_q == OP_MUL);

  shift_add_multiplier #(.WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (d0_q),
    .b       (d1_q),
    .product (mul_product),
    .done    (mul_done)
  );

  always_comb begin
    sum_d       = {1'b0, d0_q} + {1'b0, d1_q};
    result_d    = '0;
    err_d       = 1'b0;
    exec_done_d = 1'b1;
    case (op_q)
      OP_ADD:  result_d = {{(DATA_WIDTH-1){1'b0}}, sum_d};
      OP_MUL: begin
        result_d    = mul_product;
        exec_done_d = mul_done;
      end
      default: err_d = 1'b1;
    endcase
  end

  // w_en is registered: the push decision uses full_out one edge ahead, so the strobe lands in PUSH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_en_q  <= 1'b0;
      w_en_q  <= 1'b0;
      first_q <= 1'b0;
      wdata_q <= '0;
      ops_q   <= '0;
      op_q    <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      r_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty_in) begin
            state_q <= S_FETCH;
            r_en_q  <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          op_q    <= rdata_in[IN_OP_LSB +: OPERATION_SIZE];
          d1_q    <= rdata_in[IN_D1_LSB +: DATA_WIDTH];
          d0_q    <= rdata_in[IN_D0_LSB +: DATA_WIDTH];
          first_q <= 1'b1;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          first_q <= 1'b0;
          if (exec_done_d) begin
            wdata_q <= {err_d, result_d};
            w_en_q  <= !full_out;
            if (!full_out) ops_q <= ops_q + CNT_WIDTH'(1);
            state_q <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (w_en_q) begin
            w_en_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (!full_out) begin
            w_en_q <= 1'b1;
            ops_q  <= ops_q + CNT_WIDTH'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign r_en_in   = r_en_q;
  assign w_en_out  = w_en_q;
  assign wdata_out = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_alu_exec_engine.sv
// tb/tb_alu_exec_engine.sv - vector table plus hand sequences against a FIFO model and push scoreboard
module tb_alu_exec_engine;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        empty_in = 1'b1;
  logic        full_out = 1'b0;
  logic [25:0] rdata_in = '0;
  logic        r_en_in, w_en_out, busy;
  logic [24:0] wdata_out;
  logic [7:0]  ops_done;

  alu_exec_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .empty_in  (empty_in),
    .rdata_in  (rdata_in),
    .r_en_in   (r_en_in),
    .full_out  (full_out),
    .w_en_out  (w_en_out),
    .wdata_out (wdata_out),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] d1;
    logic [11:0] d0;
    logic [24:0] exp;
  } vec_t;

  typedef struct {
    logic [24:0] word;
    int          lat;
  } sb_t;

  sb_t         sb[$];
  logic [25:0] fifo[$];
  vec_t        vecs[10];

  int n_pass = 0, n_total = 0;
  int cyc = 0, t_ren = 0, t_last_push = -1, n_push = 0, ren_cycles = 0, exp_ren = 0;
  bit spacing_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int lat_of(input logic [1:0] op);
    return (op == 2'b10) ? 14 : 3;
  endfunction

  task automatic enqueue(input logic [1:0] op, input logic [11:0] d1, input logic [11:0] d0,
                         input logic [24:0] exp, input int lat);
    fifo.push_back({op, d1, d0});
    empty_in = 1'b0;
    sb.push_back('{exp, lat});
    exp_ren++;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && fifo.size() == 0 && !busy) return;
    end
    n_total++;
    $display("FAIL drain_timeout: got %0d results outstanding expected 0 within %0d cycles", sb.size(), budget);
  endtask

  task automatic wait_ren(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (r_en_in) return;
    end
    n_total++;
    $display("FAIL ren_timeout: got no r_en_in expected one within %0d cycles", budget);
  endtask

  always @(posedge clk) cyc++;

  // FIFO_IN model: word appears on rdata_in the cycle after the pop strobe
  always @(negedge clk) begin
    if (rst_n && r_en_in) begin
      if (fifo.size() > 0) rdata_in = fifo.pop_front();
      empty_in = (fifo.size() == 0);
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (r_en_in) begin
      ren_cycles++;
      t_ren = cyc;
    end
    if (w_en_out) begin
      n_push++;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_push: got %h expected no push", wdata_out);
      end else begin
        e = sb.pop_front();
        check("push_data", wdata_out, e.word);
        if (e.lat >= 0) check("latency", cyc - t_ren, e.lat);
        check("busy_at_push", busy, 1'b1);
        if (spacing_on && t_last_push >= 0) check("push_spacing", cyc - t_last_push, 5);
        t_last_push = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int pb;
    logic [11:0] ra, rb;

    vecs[0] = '{2'b01, 12'h001, 12'hFFF, 25'h0001000};
    vecs[1] = '{2'b10, 12'hFFF, 12'hFFF, 25'h0FFE001};
    vecs[2] = '{2'b00, 12'h005, 12'h003, 25'h1000000};
    vecs[3] = '{2'b01, 12'h000, 12'h000, 25'h0000000};
    vecs[4] = '{2'b01, 12'hFFF, 12'hFFF, 25'h0001FFE};
    vecs[5] = '{2'b10, 12'h123, 12'h456, 25'h004EDC2};
    vecs[6] = '{2'b10, 12'h000, 12'hABC, 25'h0000000};
    vecs[7] = '{2'b11, 12'h0AA, 12'h055, 25'h1000000};
    vecs[8] = '{2'b10, 12'h001, 12'hFFF, 25'h0000FFF};
    vecs[9] = '{2'b10, 12'h800, 12'h800, 25'h0400000};

    repeat (3) @(negedge clk);
    check("rst_r_en", r_en_in, 1'b0);
    check("rst_w_en", w_en_out, 1'b0);
    check("rst_wdata", wdata_out, 25'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ops_done", ops_done, 8'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      enqueue(vecs[i].op, vecs[i].d1, vecs[i].d0, vecs[i].exp, lat_of(vecs[i].op));
      wait_drain(60);
      check("ops_done_vec", ops_done, i + 1);
    end

    // backpressure: FIFO_OUT full from PUSH entry for 5 cycles
    enqueue(2'b01, 12'h234, 12'h111, 25'h0000345, -1);
    wait_ren(20);
    full_out = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_w_en_low", w_en_out, 1'b0);
      check("bp_wdata_hold", wdata_out, 25'h0000345);
      check("bp_busy", busy, 1'b1);
    end
    pb = n_push;
    full_out = 1'b0;
    wait_drain(20);
    check("bp_single_push", n_push, pb + 1);
    check("bp_ops_done", ops_done, 8'd11);

    // reset in the middle of a MUL, at EXEC step 6
    enqueue(2'b10, 12'hFFF, 12'hFFF, 25'h0FFE001, 14);
    wait_ren(20);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_r_en", r_en_in, 1'b0);
    check("mrst_w_en", w_en_out, 1'b0);
    check("mrst_ops_done", ops_done, 8'h0);
    check("mrst_wdata", wdata_out, 25'h0);
    sb.delete();
    pb = n_push;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("mrst_no_push", n_push, pb);
    check("mrst_idle", busy, 1'b0);

    // three ADDs queued back to back
    spacing_on = 1'b1;
    t_last_push = -1;
    pb = n_push;
    enqueue(2'b01, 12'h010, 12'h020, 25'h0000030, 3);
    enqueue(2'b01, 12'h800, 12'h800, 25'h0001000, 3);
    enqueue(2'b01, 12'h123, 12'h321, 25'h0000444, 3);
    wait_drain(60);
    spacing_on = 1'b0;
    check("b2b_pushes", n_push, pb + 3);
    check("b2b_ops_done", ops_done, 8'd3);

    // ops_done wraps after 256 pushes
    for (int i = 0; i < 253; i++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      enqueue(2'b01, ra, rb, 25'(ra) + 25'(rb), 3);
      wait_drain(20);
    end
    check("wrap_ops_done", ops_done, 8'd0);
    enqueue(2'b10, 12'h002, 12'h003, 25'h0000006, 14);
    wait_drain(40);
    check("post_wrap_ops_done", ops_done, 8'd1);

    check("ren_cycles", ren_cycles, exp_ren);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
